// File: rtl/matmul_seq_ctrl.sv
// Command sequencer for the systolic matrix-multiply array.
// Each accepted command runs FEED, then FLUSH, then DRAIN (with consumer backpressure), then DONE.
module matmul_seq_ctrl #(
  parameter int unsigned SYS_ARRAY_SIZE = 2,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned FEED_CYCLES    = SYS_ARRAY_SIZE,
  parameter int unsigned PIPE_CYCLES    = 2 * SYS_ARRAY_SIZE - 2,
  parameter int unsigned DRAIN_CYCLES   = 2 * SYS_ARRAY_SIZE,
  localparam int unsigned COUNT_WIDTH   = (FEED_CYCLES > 1) ? $clog2(FEED_CYCLES) : 1,
  localparam int unsigned DCOUNT_WIDTH  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1,
  localparam int unsigned CTRL_WIDTH    = 2 + 3 * ADDR_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_a_addr_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_b_addr_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_c_addr_i,
  input  logic                    drain_stall_i,
  output logic [CTRL_WIDTH-1:0]   ctrl_o,
  output logic [COUNT_WIDTH-1:0]  feed_count_o,
  output logic                    feed_last_o,
  output logic [DCOUNT_WIDTH-1:0] drain_count_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned MAX_FP     = (FEED_CYCLES > PIPE_CYCLES) ? FEED_CYCLES : PIPE_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_FP > DRAIN_CYCLES) ? MAX_FP : DRAIN_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYCLES - 1);
  localparam logic [CNT_W-1:0] PIPE_LAST  = (PIPE_CYCLES > 0) ? CNT_W'(PIPE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [ADDR_WIDTH-1:0] c_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= '0;
      a_addr <= '0;
      b_addr <= '0;
      c_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            a_addr <= cmd_a_addr_i;
            b_addr <= cmd_b_addr_i;
            c_addr <= cmd_c_addr_i;
            cnt    <= '0;
            state  <= FEED;
          end
        end
        FEED: begin
          if (cnt == FEED_LAST) begin
            cnt   <= '0;
            state <= (PIPE_CYCLES == 0) ? DRAIN : FLUSH;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FLUSH: begin
          if (cnt == PIPE_LAST) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DRAIN: begin
          // A stalled beat holds the index so the consumer sees every beat exactly once.
          if (!drain_stall_i) begin
            if (cnt == DRAIN_LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign feed_count_o  = (state == FEED) ? COUNT_WIDTH'(cnt) : '0;
  assign feed_last_o   = (state == FEED) && (cnt == FEED_LAST);
  assign drain_count_o = (state == DRAIN) ? DCOUNT_WIDTH'(cnt) : '0;
  assign ctrl_o        = {(state == FEED), (state == DRAIN) && !drain_stall_i,
                          a_addr, b_addr, c_addr};

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: default build plus a PIPE_CYCLES=0 build,
// compared cycle by cycle against a phase schedule built from the command timing rules.
module tb_matmul_seq_ctrl;

  localparam int AW  = 64;
  localparam int F   = 2;
  localparam int P   = 2;
  localparam int D   = 4;
  localparam int FCW = 1;
  localparam int DCW = 2;
  localparam int CW  = 2 + 3 * AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           cmd_valid, cmd_ready;
  logic [AW-1:0]  a_in, b_in, c_in;
  logic           drain_stall;
  logic [CW-1:0]  ctrl;
  logic [FCW-1:0] feed_count;
  logic           feed_last;
  logic [DCW-1:0] drain_count;
  logic           busy, done;

  logic           cmd_valid0, cmd_ready0;
  logic [AW-1:0]  a_in0, b_in0, c_in0;
  logic           drain_stall0;
  logic [CW-1:0]  ctrl0;
  logic [FCW-1:0] feed_count0;
  logic           feed_last0;
  logic [DCW-1:0] drain_count0;
  logic           busy0, done0;

  matmul_seq_ctrl #(.SYS_ARRAY_SIZE(2), .ADDR_WIDTH(AW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_addr_i(a_in), .cmd_b_addr_i(b_in), .cmd_c_addr_i(c_in),
    .drain_stall_i(drain_stall), .ctrl_o(ctrl), .feed_count_o(feed_count),
    .feed_last_o(feed_last), .drain_count_o(drain_count), .busy_o(busy), .done_o(done)
  );

  matmul_seq_ctrl #(.SYS_ARRAY_SIZE(2), .ADDR_WIDTH(AW), .PIPE_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid0), .cmd_ready_o(cmd_ready0),
    .cmd_a_addr_i(a_in0), .cmd_b_addr_i(b_in0), .cmd_c_addr_i(c_in0),
    .drain_stall_i(drain_stall0), .ctrl_o(ctrl0), .feed_count_o(feed_count0),
    .feed_last_o(feed_last0), .drain_count_o(drain_count0), .busy_o(busy0), .done_o(done0)
  );

  typedef struct {
    logic stall;
    logic cr;
    logic de;
    int   fc;
    logic fl;
    int   dc;
    logic done;
  } exp_t;

  exp_t          trace[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] last_a = '0, last_b = '0, last_c = '0;

  function automatic logic side_stall(input int mode);
    if (mode == 3) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  // mode 0: no stall; 1: beats 1 and 2 stalled 3 cycles each; 2: random; 3: stall held outside drain only
  function automatic void build(input int pipe, input int mode);
    exp_t e;
    trace.delete();
    for (int i = 0; i < F; i++) begin
      e = '{stall: side_stall(mode), cr: 1'b1, de: 1'b0, fc: i, fl: (i == F - 1), dc: 0, done: 1'b0};
      trace.push_back(e);
    end
    for (int i = 0; i < pipe; i++) begin
      e = '{stall: side_stall(mode), cr: 1'b0, de: 1'b0, fc: 0, fl: 1'b0, dc: 0, done: 1'b0};
      trace.push_back(e);
    end
    for (int b = 0; b < D; b++) begin
      int ns;
      ns = (mode == 1 && (b == 1 || b == 2)) ? 3 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < ns; s++) begin
        e = '{stall: 1'b1, cr: 1'b0, de: 1'b0, fc: 0, fl: 1'b0, dc: b, done: 1'b0};
        trace.push_back(e);
      end
      e = '{stall: 1'b0, cr: 1'b0, de: 1'b1, fc: 0, fl: 1'b0, dc: b, done: 1'b0};
      trace.push_back(e);
    end
    e = '{stall: side_stall(mode), cr: 1'b0, de: 1'b0, fc: 0, fl: 1'b0, dc: 0, done: 1'b1};
    trace.push_back(e);
  endfunction

  // Starts one command from IDLE on the default build; optional reset pulse at trace index reset_at.
  task automatic run_cmd(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                         input int mode, input bit hold, input int reset_at);
    build(P, mode);
    cmd_valid   = 1'b1;
    a_in        = a;
    b_in        = b;
    c_in        = c;
    drain_stall = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_status: ready=%b busy=%b done=%b, expected 1 0 0", cmd_ready, busy, done);
    end
    checks++;
    if (ctrl !== {2'b00, last_a, last_b, last_c} || feed_count !== '0 || drain_count !== '0) begin
      errors++;
      $display("FAIL idle_ctrl: ctrl=%h fc=%0d dc=%0d, expected %h 0 0", ctrl, feed_count,
               drain_count, {2'b00, last_a, last_b, last_c});
    end
    @(posedge clk);
    #1;
    last_a = a;
    last_b = b;
    last_c = c;
    if (!hold) cmd_valid = 1'b0;
    for (int k = 0; k < trace.size(); k++) begin
      drain_stall = trace[k].stall;
      if (hold) begin
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
        c_in = {$urandom, $urandom};
      end
      if (k == reset_at) rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl !== {trace[k].cr, trace[k].de, last_a, last_b, last_c}) begin
        errors++;
        $display("FAIL ctrl cyc%0d: got %h expected %h", k + 1, ctrl,
                 {trace[k].cr, trace[k].de, last_a, last_b, last_c});
      end
      checks++;
      if (feed_count !== FCW'(trace[k].fc) || feed_last !== trace[k].fl
          || drain_count !== DCW'(trace[k].dc)) begin
        errors++;
        $display("FAIL counts cyc%0d: fc=%0d fl=%b dc=%0d expected %0d %b %0d", k + 1, feed_count,
                 feed_last, drain_count, trace[k].fc, trace[k].fl, trace[k].dc);
      end
      checks++;
      if (done !== trace[k].done || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL status cyc%0d: done=%b busy=%b ready=%b expected %b 1 0", k + 1, done, busy,
                 cmd_ready, trace[k].done);
      end
      @(posedge clk);
      #1;
      if (k == reset_at) begin
        rst_n  = 1'b1;
        last_a = '0;
        last_b = '0;
        last_c = '0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    a_in         = '0;
    b_in         = '0;
    c_in         = '0;
    drain_stall  = 1'b0;
    cmd_valid0   = 1'b0;
    a_in0        = '0;
    b_in0        = '0;
    c_in0        = '0;
    drain_stall0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ctrl !== '0
        || feed_count !== '0 || feed_last !== 1'b0 || drain_count !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b ctrl=%h fc=%0d fl=%b dc=%0d", cmd_ready,
               busy, done, ctrl, feed_count, feed_last, drain_count);
    end
    checks++;
    if (cmd_ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || ctrl0 !== '0) begin
      errors++;
      $display("FAIL reset_state_pipe0: ready=%b busy=%b done=%b ctrl=%h", cmd_ready0, busy0,
               done0, ctrl0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    run_cmd(64'h100, 64'h200, 64'h300, 0, 1'b0, -1);
  endtask

  task automatic test_drain_stall();
    run_cmd({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1'b0, -1);
  endtask

  task automatic test_stall_outside_drain();
    run_cmd({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 3, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_cmd({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1'b1, -1);
    run_cmd({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b1, -1);
    run_cmd({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_cmd({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1'b0, -1);
      repeat ($urandom_range(0, 2)) begin
        drain_stall = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    run_cmd({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, F + P + 2);
    @(negedge clk);
    checks++;
    if (ctrl !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0
        || drain_count !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: ctrl=%h busy=%b ready=%b done=%b dc=%0d", ctrl, busy,
               cmd_ready, done, drain_count);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_done cyc%0d: done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_pipe_zero();
    logic [AW-1:0] a, b, c;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = {$urandom, $urandom};
    build(0, 0);
    cmd_valid0 = 1'b1;
    a_in0      = a;
    b_in0      = b;
    c_in0      = c;
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0;
    for (int k = 0; k < trace.size(); k++) begin
      drain_stall0 = trace[k].stall;
      @(negedge clk);
      checks++;
      if (ctrl0 !== {trace[k].cr, trace[k].de, a, b, c} || done0 !== trace[k].done) begin
        errors++;
        $display("FAIL pipe0_ctrl cyc%0d: cr=%b de=%b done=%b expected %b %b %b", k + 1,
                 ctrl0[CW-1], ctrl0[CW-2], done0, trace[k].cr, trace[k].de, trace[k].done);
      end
      checks++;
      if (feed_count0 !== FCW'(trace[k].fc) || feed_last0 !== trace[k].fl
          || drain_count0 !== DCW'(trace[k].dc)) begin
        errors++;
        $display("FAIL pipe0_counts cyc%0d: fc=%0d fl=%b dc=%0d expected %0d %b %0d", k + 1,
                 feed_count0, feed_last0, drain_count0, trace[k].fc, trace[k].fl, trace[k].dc);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (cmd_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL pipe0_idle: ready=%b busy=%b expected 1 0", cmd_ready0, busy0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_drain_stall();
    test_stall_outside_drain();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    test_single();
    test_pipe_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer for the SYS_ARRAY_SIZE x SYS_ARRAY_SIZE systolic matrix-multiply datapath.
- Accepts one multiply command (A/B/C base addresses) over a valid/ready handshake.
- Drives the ctrl_t command word to the array: feed phase, pipeline flush, then drain phase with consumer backpressure.
- Signals completion with a single-cycle done pulse.
- Sits between the host/command interface and the array/memory feeders.

Parameters:
- SYS_ARRAY_SIZE, 2, array dimension.
- ADDR_WIDTH, 64, address width of a_addr/b_addr/c_addr.
- FEED_CYCLES, SYS_ARRAY_SIZE (T_C), cycles compute_req is held to stream operands.
- PIPE_CYCLES, 2*SYS_ARRAY_SIZE-2, flush cycles between the last feed and the first drain; 0 is legal.
- DRAIN_CYCLES, 2*SYS_ARRAY_SIZE (T_D), accepted drain beats per command.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_a_addr_i  in  ADDR_WIDTH  A base address.
- cmd_b_addr_i  in  ADDR_WIDTH  B base address.
- cmd_c_addr_i  in  ADDR_WIDTH  C base address.
- drain_stall_i  in  1  drain consumer backpressure.
- ctrl_o  out  ctrl_t (2+3*ADDR_WIDTH)  {compute_req, drain_en, a_addr, b_addr, c_addr} to the array.
- feed_count_o  out  COUNT_WIDTH (mcount_t)  feed beat index.
- feed_last_o  out  1  last feed beat; drives matrix_data_t.last.
- drain_count_o  out  $clog2(DRAIN_CYCLES)  drain beat index.
- busy_o  out  1  command in flight.
- done_o  out  1  completion pulse.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni. Reset is sampled only at the clk_i edge.
- States: IDLE, FEED, FLUSH, DRAIN, DONE. A single shared phase counter, cnt, is wide enough for max(FEED_CYCLES, PIPE_CYCLES, DRAIN_CYCLES).
- Reset (including mid-operation): state=IDLE, cnt=0, latched addresses=0. After the reset edge:
  - cmd_ready_o=1.
  - ctrl_o=0, feed_count_o=0, feed_last_o=0, drain_count_o=0, busy_o=0, done_o=0.
  - Any in-flight command is discarded; no done_o is issued for it.
- IDLE:
  - cmd_ready_o=1, busy_o=0.
  - On cmd_valid_i=1 at the edge: latch all three addresses, cnt<=0, go to FEED.
  - cmd_ready_o=0 in every other state. Commands are never queued.
- FEED:
  - compute_req=1, feed_count_o=cnt, feed_last_o=(cnt==FEED_CYCLES-1), busy_o=1.
  - At cnt==FEED_CYCLES-1: cnt<=0, go to FLUSH, or straight to DRAIN if PIPE_CYCLES==0.
- FLUSH:
  - compute_req=0, drain_en=0, busy_o=1.
  - After PIPE_CYCLES cycles: cnt<=0, go to DRAIN.
- DRAIN:
  - drain_en = !drain_stall_i (combinational); drain_count_o=cnt; busy_o=1.
  - cnt advances only on cycles with drain_stall_i=0.
  - On an unstalled beat with cnt==DRAIN_CYCLES-1: go to DONE.
  - Stall length is unbounded.
  - drain_stall_i is ignored outside DRAIN.
- DONE:
  - done_o=1 for exactly one cycle; busy_o=1; compute_req=0, drain_en=0.
  - Next state is IDLE.
- Address fields of ctrl_o:
  - Show the latched values from acceptance through DONE.
  - Hold those values in IDLE until the next acceptance; they are not cleared by completion.
- compute_req and drain_en are never 1 in the same cycle.
- feed_count_o and drain_count_o read 0 outside their own phase.
- Latency with defaults, no stalls:
  - Accept at edge N.
  - FEED cycles N+1..N+2, FLUSH N+3..N+4, DRAIN N+5..N+8, DONE N+9.
  - cmd_ready_o=1 again at N+10.
  - Each stalled drain cycle adds exactly 1 cycle.
- Width rules:
  - Counters compare with the exact terminal value and never wrap inside a phase.
  - With FEED_CYCLES=1, feed_last_o=1 on the single feed beat.

Test Plan:
- Reset then single command (a=0x100, b=0x200, c=0x300), no stall:
  - compute_req=1 for 2 cycles with feed_count 0,1 and feed_last_o on beat 1.
  - Then 2 flush cycles, then drain_en=1 for 4 cycles with drain_count 0..3.
  - done_o pulse at N+9; cmd_ready_o=1 at N+10; ctrl_o addresses still 0x100/0x200/0x300 in IDLE.
- Drain stall: drain_stall_i=1 on drain beats 1 and 2 for 3 cycles each:
  - drain_en=0 and drain_count_o frozen at 1 and 2 during the stalls.
  - done_o at N+15.
- cmd_valid_i held high continuously:
  - Second command accepted only in IDLE after done_o.
  - cmd_ready_o=0 throughout FEED..DONE; new addresses latched only at the second acceptance.
- rst_ni=0 for one edge mid-DRAIN (drain beat 2):
  - Next cycle state IDLE, ctrl_o=0, busy_o=0, cmd_ready_o=1.
  - No done_o pulse.
- PIPE_CYCLES=0 build: FEED beat 1 is followed immediately by drain beat 0 in the next cycle; done_o at N+7.
- drain_stall_i=1 throughout FEED and FLUSH: no effect on timing; drain starts at N+5.
